// File: rtl/dcache_ctrl.sv
// Data-cache miss/flush controller: write-back of dirty victims, two-word block fills,
// and a halt-triggered flush walk over all eight frame-set indices.
//
// state | meaning
// IDLE  | serve hits, start a miss or a flush
// WB0   | write back word 0 of the selected frame
// WB1   | write back word 1 of the selected frame
// LD0   | fetch word 0 of the requested block
// LD1   | fetch word 1, then validate and tag the frame
// FCHK  | flush walk: inspect frame at ctr
// FNEXT | flush walk: advance ctr or finish
// FDONE | flush complete, requests ignored until reset
module dcache_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic        halt,
   input  logic        hit,
   input  logic        frame_valid,
   input  logic        frame_dirty,
   input  logic [25:0] frame_tag,
   input  logic [31:0] frame_data0,
   input  logic [31:0] frame_data1,
   input  logic        dwait,
   output logic        dhit,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   output logic        latch_en,
   output logic        replace,
   output logic        load_data,
   output logic        set_valid,
   output logic        clear_dirty,
   output logic        write_tag,
   output logic        write_offset,
   output logic        idx_sel,
   output logic [2:0]  flush_idx,
   output logic        flushed
);

   typedef enum logic [2:0] {IDLE, WB0, WB1, LD0, LD1, FCHK, FNEXT, FDONE} state_t;

   state_t      r_state;
   logic [2:0]  r_ctr;
   logic        r_flushing;
   logic        r_flushed;

   logic        w_req;
   logic        w_hit;
   logic        w_dirty;
   logic        w_idx_sel;
   logic [2:0]  w_idx;
   logic        w_done;

   assign w_req     = dmemREN | dmemWEN;
   assign w_hit     = hit & frame_valid;
   assign w_dirty   = frame_valid & frame_dirty;
   assign w_idx_sel = (r_state == FCHK) || (r_state == FNEXT) ||
                      (((r_state == WB0) || (r_state == WB1)) && r_flushing);
   assign w_idx     = w_idx_sel ? r_ctr : dmemaddr[5:3];
   // a reset edge must never coincide with a frame update
   assign w_done    = !dwait && nRST;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state    <= IDLE;
         r_ctr      <= 3'd0;
         r_flushing <= 1'b0;
         r_flushed  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (halt) begin
                  r_state    <= FCHK;
                  r_ctr      <= 3'd0;
                  r_flushing <= 1'b1;
               end else if (w_req && !w_hit) begin
                  r_state <= w_dirty ? WB0 : LD0;
               end
            end
            WB0:   if (!dwait) r_state <= WB1;
            WB1:   if (!dwait) r_state <= r_flushing ? FNEXT : LD0;
            LD0:   if (!dwait) r_state <= LD1;
            LD1:   if (!dwait) r_state <= IDLE;
            FCHK:  r_state <= w_dirty ? WB0 : FNEXT;
            FNEXT: begin
               if (r_ctr == 3'd7) begin
                  r_state    <= FDONE;
                  r_flushing <= 1'b0;
                  r_flushed  <= 1'b1;
               end else begin
                  r_ctr   <= r_ctr + 3'd1;
                  r_state <= FCHK;
               end
            end
            FDONE:   r_state <= FDONE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      dREN         = 1'b0;
      dWEN         = 1'b0;
      daddr        = 32'd0;
      dstore       = 32'd0;
      latch_en     = 1'b0;
      replace      = 1'b0;
      load_data    = 1'b0;
      set_valid    = 1'b0;
      clear_dirty  = 1'b0;
      write_tag    = 1'b0;
      write_offset = 1'b0;
      case (r_state)
         WB0: begin
            dWEN   = 1'b1;
            daddr  = {frame_tag, w_idx, 1'b0, 2'b00};
            dstore = frame_data0;
         end
         WB1: begin
            dWEN   = 1'b1;
            daddr  = {frame_tag, w_idx, 1'b1, 2'b00};
            dstore = frame_data1;
            if (w_done && r_flushing) begin
               latch_en    = 1'b1;
               replace     = 1'b1;
               clear_dirty = 1'b1;
            end
         end
         LD0: begin
            dREN  = 1'b1;
            daddr = {dmemaddr[31:6], w_idx, 1'b0, 2'b00};
            if (w_done) begin
               latch_en  = 1'b1;
               replace   = 1'b1;
               load_data = 1'b1;
            end
         end
         LD1: begin
            dREN  = 1'b1;
            daddr = {dmemaddr[31:6], w_idx, 1'b1, 2'b00};
            if (w_done) begin
               latch_en     = 1'b1;
               replace      = 1'b1;
               load_data    = 1'b1;
               write_offset = 1'b1;
               set_valid    = 1'b1;
               clear_dirty  = 1'b1;
               write_tag    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign dhit      = (r_state == IDLE) && !halt && w_req && w_hit;
   assign idx_sel   = w_idx_sel;
   assign flush_idx = r_ctr;
   assign flushed   = r_flushed;

endmodule
